// File: rtl/ram_dump_tx.sv
// Streams a RAM region out of an 8N1 UART. The frame is the "TEKNOFEST" banner,
// then the 32-bit word count, then every word MSB first.
module ram_dump_tx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [31:0]       word_cnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              tx_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [2:0] {IDLE, HDR, LEN, RD, CAP, DATA, FIN} state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr;
  logic [31:0]       word_cnt_q;
  logic [31:0]       words_sent;
  logic [DATA_W-1:0] word_reg;
  logic [9:0]        tx_shift;
  logic [3:0]        bit_idx;
  logic [CNT_W-1:0]  clk_cnt;
  logic              tx_active;
  logic [3:0]        byte_idx;
  logic [3:0]        next_idx;
  logic              bit_end;
  logic              byte_done;
  logic              load_en;
  logic [7:0]        load_byte;
  logic [3:0]        load_idx;
  logic              word_end;

  function automatic logic [7:0] hdr_byte(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h54;
      4'd1:    return 8'h45;
      4'd2:    return 8'h4B;
      4'd3:    return 8'h4E;
      4'd4:    return 8'h4F;
      4'd5:    return 8'h46;
      4'd6:    return 8'h45;
      4'd7:    return 8'h53;
      default: return 8'h54;
    endcase
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  assign bit_end   = tx_active && (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign byte_done = bit_end && (bit_idx == 4'd9);
  assign next_idx  = byte_idx + 4'd1;
  assign rd_addr_o = addr;
  assign tx_o      = tx_active ? tx_shift[0] : 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // The next byte is loaded on the same edge the previous stop bit ends,
  // so bytes inside a section go out with no gap.
  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    rd_en_o    = 1'b0;
    load_en    = 1'b0;
    load_byte  = 8'h00;
    load_idx   = next_idx;
    word_end   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = HDR;
          load_en    = 1'b1;
          load_byte  = hdr_byte(4'd0);
          load_idx   = 4'd0;
        end
      end
      HDR: begin
        busy_o = 1'b1;
        if (byte_done) begin
          load_en = 1'b1;
          if (byte_idx == 4'd8) begin
            state_next = LEN;
            load_byte  = word_byte(word_cnt_q, 2'd0);
            load_idx   = 4'd0;
          end else begin
            load_byte = hdr_byte(next_idx);
          end
        end
      end
      LEN: begin
        busy_o = 1'b1;
        if (byte_done) begin
          if (byte_idx == 4'd3) begin
            state_next = (word_cnt_q != 32'd0) ? RD : FIN;
          end else begin
            load_en   = 1'b1;
            load_byte = word_byte(word_cnt_q, next_idx[1:0]);
          end
        end
      end
      RD: begin
        busy_o     = 1'b1;
        rd_en_o    = 1'b1;
        state_next = CAP;
      end
      CAP: begin
        busy_o     = 1'b1;
        state_next = DATA;
        load_en    = 1'b1;
        load_byte  = word_byte(rd_data_i, 2'd0);
        load_idx   = 4'd0;
      end
      DATA: begin
        busy_o = 1'b1;
        if (byte_done) begin
          if (byte_idx == 4'd3) begin
            word_end   = 1'b1;
            state_next = ((words_sent + 32'd1) == word_cnt_q) ? FIN : RD;
          end else begin
            load_en   = 1'b1;
            load_byte = word_byte(word_reg, next_idx[1:0]);
          end
        end
      end
      FIN: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shifter holds {stop, data, start} and moves right once per bit period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr       <= '0;
      word_cnt_q <= '0;
      words_sent <= '0;
      word_reg   <= '0;
      tx_shift   <= '1;
      bit_idx    <= '0;
      clk_cnt    <= '0;
      tx_active  <= 1'b0;
      byte_idx   <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        addr       <= base_addr_i;
        word_cnt_q <= word_cnt_i;
        words_sent <= '0;
      end
      if (state == CAP) word_reg <= rd_data_i;
      if (word_end) begin
        addr       <= addr + ADDR_W'(1);
        words_sent <= words_sent + 32'd1;
      end
      if (load_en) begin
        tx_shift  <= {1'b1, load_byte, 1'b0};
        bit_idx   <= '0;
        clk_cnt   <= '0;
        tx_active <= 1'b1;
        byte_idx  <= load_idx;
      end else if (tx_active) begin
        if (bit_end) begin
          clk_cnt <= '0;
          if (bit_idx == 4'd9) begin
            tx_active <= 1'b0;
          end else begin
            bit_idx  <= bit_idx + 4'd1;
            tx_shift <= {1'b1, tx_shift[9:1]};
          end
        end else begin
          clk_cnt <= clk_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_dump_tx.sv
// Scoreboard bench for ram_dump_tx: a UART decoder and read-address monitor
// pop expected bytes/addresses that applyStimulus pushes for each dump.
module tb_ram_dump_tx;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [31:0]   word_cnt_i;
  logic          busy_o;
  logic          done_o;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [31:0]   rd_data_i;
  logic          tx_o;

  logic [31:0] ram [16];
  logic [7:0]  hdr [9] = '{8'h54, 8'h45, 8'h4B, 8'h4E, 8'h4F, 8'h46, 8'h45, 8'h53, 8'h54};
  logic [31:0] exp_bytes[$];
  logic [31:0] exp_addr[$];

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int rd_seen = 0;

  ram_dump_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .word_cnt_i(word_cnt_i), .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .tx_o(tx_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model: data valid the cycle after rd_en_o.
  always @(posedge clk) begin
    if (rd_en_o === 1'b1) rd_data_i <= ram[rd_addr_o];
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // UART decoder: detects a start bit and samples every bit near its centre.
  initial begin : uart_mon
    logic [7:0]  b;
    logic        stop_bit;
    logic [31:0] e;
    bit          ab;
    forever begin
      @(negedge clk);
      if (rst_i === 1'b0 && tx_o === 1'b0) begin
        ab = 0;
        b = '0;
        stop_bit = 1'b0;
        for (int c = 1; c <= 9 * CPB + 1; c++) begin
          @(negedge clk);
          if (rst_i !== 1'b0) ab = 1;
          if (c >= CPB + 1 && c <= 8 * CPB + 1 && ((c - CPB - 1) % CPB) == 0)
            b[(c - CPB - 1) / CPB] = tx_o;
          if (c == 9 * CPB + 1) stop_bit = tx_o;
        end
        if (!ab) begin
          e = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 32'hDEAD_0000;
          checkOutput("tx_byte", {24'd0, b}, e);
          checkOutput("stop_bit", 32'(stop_bit), 32'd1);
        end
      end
    end
  end

  initial begin : rd_mon
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_i === 1'b0 && rd_en_o === 1'b1) begin
        rd_seen++;
        e = (exp_addr.size() != 0) ? exp_addr.pop_front() : 32'hFFFF_FFFF;
        checkOutput("rd_addr", 32'(rd_addr_o), e);
      end
      if (rst_i === 1'b0 && done_o === 1'b1) done_seen++;
    end
  end

  task automatic pushFrame(input logic [AW-1:0] base, input logic [31:0] n);
    logic [AW-1:0] a;
    logic [31:0]   w;
    for (int i = 0; i < 9; i++) exp_bytes.push_back({24'd0, hdr[i]});
    exp_bytes.push_back({24'd0, n[31:24]});
    exp_bytes.push_back({24'd0, n[23:16]});
    exp_bytes.push_back({24'd0, n[15:8]});
    exp_bytes.push_back({24'd0, n[7:0]});
    for (int i = 0; i < int'(n); i++) begin
      a = base + AW'(i);
      w = ram[a];
      exp_addr.push_back(32'(a));
      exp_bytes.push_back({24'd0, w[31:24]});
      exp_bytes.push_back({24'd0, w[23:16]});
      exp_bytes.push_back({24'd0, w[15:8]});
      exp_bytes.push_back({24'd0, w[7:0]});
    end
  endtask

  task automatic pulseStart(input logic [AW-1:0] base, input logic [31:0] n);
    @(posedge clk);
    #1;
    base_addr_i = base;
    word_cnt_i  = n;
    start_i     = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] base, input logic [31:0] n, input bit second_start);
    int cyc;
    int limit;
    int d0;
    int r0;
    pushFrame(base, n);
    d0 = done_seen;
    r0 = rd_seen;
    limit = 10 * CPB * (13 + 4 * int'(n)) + 2 * int'(n) + 100;
    pulseStart(base, n);
    @(negedge clk);
    cyc = 1;
    checkOutput("busy_after_start", 32'(busy_o), 32'd1);
    while (done_o !== 1'b1 && cyc < limit) begin
      if (second_start && cyc == 100) begin
        start_i     = 1'b1;
        base_addr_i = base + AW'(3);
        word_cnt_i  = n + 32'd5;
      end else if (second_start && cyc == 101) begin
        start_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("done_timeout", 32'(done_o), 32'd1);
    checkOutput("frame_cycles", 32'(cyc), 32'(10 * CPB * (13 + 4 * int'(n)) + 2 * int'(n) + 1));
    checkOutput("busy_in_fin", 32'(busy_o), 32'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done_o), 32'd0);
    checkOutput("done_count", 32'(done_seen - d0), 32'd1);
    checkOutput("rd_count", 32'(rd_seen - r0), n);
    checkOutput("bytes_left", 32'(exp_bytes.size()), 32'd0);
    checkOutput("addr_left", 32'(exp_addr.size()), 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("idle_after_frame", {30'd0, busy_o, tx_o}, 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    int cyc;
    int d0;
    int r0;
    for (int i = 0; i < 16; i++) ram[i] = $urandom;
    ram[2] = 32'hDEAD_BEEF;
    ram[3] = 32'h0102_0304;
    rst_i = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    word_cnt_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tx", 32'(tx_o), 32'd1);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_rd_en", 32'(rd_en_o), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);

    applyStimulus(4'd0, 32'd0, 0);
    applyStimulus(4'd2, 32'd2, 0);
    applyStimulus(4'd15, 32'd2, 0);
    applyStimulus(4'd5, 32'd1, 1);
    applyStimulus(AW'($urandom_range(0, 15)), 32'd3, 0);

    // Reset in the middle of the second byte of the first data word.
    pushFrame(4'd2, 32'd2);
    r0 = rd_seen;
    pulseStart(4'd2, 32'd2);
    cyc = 0;
    while (rd_seen == r0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reach_rd_timeout", 32'(rd_seen - r0), 32'd1);
    repeat (60) @(negedge clk);
    d0 = done_seen;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    checkOutput("abort_tx", 32'(tx_o), 32'd1);
    checkOutput("abort_busy", 32'(busy_o), 32'd0);
    checkOutput("abort_done", 32'(done_o), 32'd0);
    repeat (100) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_seen - d0), 32'd0);
    checkOutput("abort_idle", {30'd0, busy_o, tx_o}, 32'd1);
    exp_bytes.delete();
    exp_addr.delete();

    applyStimulus(4'd2, 32'd2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_dump_tx.md
RAM_DUMP_TX -- requirements
Module: ram_dump_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, meaning clk_i cycles per UART bit (100 MHz / 9600 baud).
REQ-002 SHALL have parameter ADDR_W, default 17, meaning RAM word-address width (131072 words).
REQ-003 SHALL have parameter DATA_W, fixed at 32, meaning RAM word width; other values are unsupported.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port start_i, input, 1 bit: single-cycle request to begin a dump.
REQ-007 SHALL have port base_addr_i, input, ADDR_W bits: first RAM word address, sampled on an accepted start.
REQ-008 SHALL have port word_cnt_i, input, 32 bits: number of words to send, sampled on an accepted start.
REQ-009 SHALL have port busy_o, output, 1 bit: high from the cycle after an accepted start until done_o.
REQ-010 SHALL have port done_o, output, 1 bit: one-cycle pulse when the dump completes.
REQ-011 SHALL have port rd_en_o, output, 1 bit: RAM read enable.
REQ-012 SHALL have port rd_addr_o, output, ADDR_W bits: RAM read address.
REQ-013 SHALL have port rd_data_i, input, 32 bits: RAM read data, valid the cycle after rd_en_o.
REQ-014 SHALL have port tx_o, output, 1 bit: UART serial out, 8N1, LSB first, idle high.

Function
REQ-015 SHALL emit the frame in this order: ASCII "TEKNOFEST" (9 bytes, 'T' first); word_cnt as 4 bytes, MSB first; then each word as 4 bytes, MSB first, addresses base, base+1, ...
REQ-016 SHALL use this state set: IDLE, HDR, LEN, RD, CAP, DATA, FIN.
REQ-017 SHALL accept start_i only in IDLE; start_i in any other state SHALL be ignored.
REQ-018 On acceptance SHALL latch base_addr_i and word_cnt_i, and SHALL go to HDR on the next cycle.
REQ-019 In HDR, after the 9th byte's stop bit, SHALL go to LEN; in LEN, after the 4th byte's stop bit, SHALL go to RD if word_cnt != 0, else to FIN.
REQ-020 In RD (one cycle) SHALL drive rd_en_o=1 with rd_addr_o = current address; in CAP (one cycle) SHALL register rd_data_i, then go to DATA.
REQ-021 In DATA, after the 4th byte's stop bit, SHALL increment the address and word counter, then go to RD, or to FIN when the counter equals the latched word_cnt.
REQ-022 In FIN (one cycle) SHALL pulse done_o=1 and drop busy_o, then return to IDLE.
REQ-023 Each UART bit SHALL last exactly CLKS_PER_BIT cycles; each byte is 10 bits (start=0, d0..d7, stop=1).
REQ-024 Within HDR, LEN and the 4 bytes of a word, consecutive bytes SHALL be back-to-back (next start bit on the cycle after the previous stop bit).
REQ-025 Exactly 2 idle-high cycles (RD, CAP) SHALL precede the first byte of every word.
REQ-026 Address increment SHALL wrap modulo 2^ADDR_W.
REQ-027 word_cnt SHALL be treated as unsigned 32-bit, with no upper limit other than the counter width.
REQ-028 rd_en_o SHALL be 0 in every state except RD.
REQ-029 tx_o SHALL be 1 whenever no byte is being shifted.

Reset
REQ-030 While rst_i is high at a clock edge, next cycle SHALL be: state IDLE, tx_o=1, busy_o=0, done_o=0, rd_en_o=0, rd_addr_o=0, and all counters 0.
REQ-031 Reset asserted mid-byte SHALL abort the frame, return tx_o high on the next cycle, and emit no done_o pulse.

Verification (CLKS_PER_BIT=4, ADDR_W=4)
REQ-032 Scenario: start with word_cnt=0 -> tx_o decodes 54 45 4B 4E 4F 46 45 53 54 00 00 00 00; done_o pulses once; rd_en_o never asserted.
REQ-033 Scenario: RAM[2]=0xDEADBEEF, RAM[3]=0x01020304, base=2, cnt=2 -> after the header, tx_o decodes 00 00 00 02 DE AD BE EF 01 02 03 04; rd_addr_o sequence is 2, 3; total time = 21 bytes*40 + 2*2 idle cycles.
REQ-034 Scenario: base=15, cnt=2 -> reads at addresses 15 then 0 (wrap).
REQ-035 Scenario: second start_i pulse during HDR -> ignored; a single frame is emitted; latched base/cnt are unchanged.
REQ-036 Scenario: rst_i asserted during a DATA byte -> next cycle tx_o=1, busy_o=0, no done_o; a new start afterwards produces a full correct frame.
REQ-037 Scenario: loopback of tx_o into the team's UART-programmed RAM receiver -> receiver RAM contents equal the source words.
